// File: rtl/sp_ram_pkg.sv
// Shared types and default parameter values for the clearable single-port RAM.
package sp_ram_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } seq_state_e;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_RDW_MODE = 0;
    localparam int DEF_OUT_REG  = 0;

endpackage

// File: rtl/sp_ram_clr_seq.sv
// Clear sequencer: sweeps an up-counter over every address once per clear request.
//
//   state | meaning
//   IDLE  | normal access allowed, counter held at 0
//   CLEAR | one zero-write per cycle to o_cnt, busy asserted
module sp_ram_clr_seq
    import sp_ram_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_cnt
);

    seq_state_e        r_state;
    seq_state_e        w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic              r_busy;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= (w_state_nxt == CLEAR);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (i_clr) w_state_nxt = CLEAR;
            end
            CLEAR: begin
                // Wraps back to 0 on the last address, ready for the next sweep.
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == {ADDR_W{1'b1}}) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign o_busy = r_busy;
    assign o_cnt  = r_cnt;

endmodule

// File: rtl/sp_ram_clr.sv
// Single-port RAM with byte-enabled writes, selectable read-during-write behaviour,
// optional output register and a full-array clear sweep.
module sp_ram_clr
    import sp_ram_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int RDW_MODE = DEF_RDW_MODE,
    parameter int OUT_REG  = DEF_OUT_REG
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                we,
    input  logic [DATA_W/8-1:0] be,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   din,
    input  logic                clr,
    output logic [DATA_W-1:0]   dout,
    output logic                dout_valid,
    output logic                busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_dout;
    logic              r_valid;

    logic              w_busy;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_accept;
    logic [DATA_W-1:0] w_old;
    logic [DATA_W-1:0] w_merged;
    logic [DATA_W-1:0] w_rd;

    sp_ram_clr_seq #(
        .ADDR_W (ADDR_W)
    ) u_seq (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_clr  (clr),
        .o_busy (w_busy),
        .o_cnt  (w_clr_addr)
    );

    // No access may slip into the array while reset is held.
    assign w_accept = en & ~w_busy & ~rst;
    assign w_old    = r_mem[addr];

    always_comb begin
        w_merged = w_old;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) w_merged[8*i +: 8] = din[8*i +: 8];
        end
    end

    assign w_rd = (RDW_MODE == 1 && we) ? w_merged : w_old;

    always_ff @(posedge clk) begin
        if (w_busy) begin
            r_mem[w_clr_addr] <= '0;
        end else if (w_accept && we) begin
            r_mem[addr] <= w_merged;
        end
    end

    generate
        if (OUT_REG == 1) begin : g_out_reg
            logic [DATA_W-1:0] r_pipe;
            logic              r_pipe_vld;

            // Stage 1 is captured at accept time, so a sweep starting behind it cannot alter it.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_pipe     <= '0;
                    r_pipe_vld <= 1'b0;
                    r_dout     <= '0;
                    r_valid    <= 1'b0;
                end else begin
                    r_pipe_vld <= w_accept;
                    if (w_accept) r_pipe <= w_rd;
                    r_valid <= r_pipe_vld;
                    if (r_pipe_vld) r_dout <= r_pipe;
                end
            end
        end else begin : g_out_direct
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_dout  <= '0;
                    r_valid <= 1'b0;
                end else begin
                    r_valid <= w_accept;
                    if (w_accept) r_dout <= w_rd;
                end
            end
        end
    endgenerate

    assign dout       = r_dout;
    assign dout_valid = r_valid;
    assign busy       = w_busy;

endmodule

// File: tb/tb_sp_ram_clr.sv
// Scoreboard bench: two RAM variants (read-first/no out reg, write-first/out reg) share stimulus.
module tb_sp_ram_clr;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        we = 1'b0;
    logic        clr = 1'b0;
    logic [1:0]  be = 2'b00;
    logic [3:0]  addr = 4'd0;
    logic [15:0] din = 16'd0;
    logic [15:0] dout0, dout1;
    logic        v0, v1, busy0, busy1;

    always #5 clk = ~clk;

    sp_ram_clr #(.DATA_W(16), .ADDR_W(4), .RDW_MODE(0), .OUT_REG(0)) u_dut0 (
        .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .din(din),
        .clr(clr), .dout(dout0), .dout_valid(v0), .busy(busy0));

    sp_ram_clr #(.DATA_W(16), .ADDR_W(4), .RDW_MODE(1), .OUT_REG(1)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .din(din),
        .clr(clr), .dout(dout1), .dout_valid(v1), .busy(busy1));

    typedef struct {
        logic [15:0] data;
        bit          dc;
        int          at;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [15:0] m_mem [16];
    bit          m_known [16];
    logic [15:0] last_v [2];
    bit          last_dc [2];
    int          edge_no = 0;
    int          clr_edge = -1;
    int          compared = 0;
    int          mismatched = 0;
    bit          started = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h required %0h (edge %0d)", name, act, req, edge_no);
        end
    endtask

    function automatic bit m_busy_at(input int e);
        return (clr_edge >= 0) && (e > clr_edge) && (e <= clr_edge + 16);
    endfunction

    task automatic check_out(input int id, input logic [15:0] d, input logic v);
        exp_t  e;
        int    qs;
        string pfx;
        pfx = (id == 0) ? "dut0" : "dut1";
        qs  = (id == 0) ? q0.size() : q1.size();
        if (v) begin
            if (qs == 0) begin
                compared++;
                mismatched++;
                $display("FAIL %s_unexpected_valid: got dout_valid=1 dout=%0h required dout_valid=0 (edge %0d)",
                         pfx, d, edge_no);
            end else begin
                if (id == 0) e = q0.pop_front();
                else         e = q1.pop_front();
                check({pfx, "_latency"}, edge_no, e.at);
                if (!e.dc) check({pfx, "_data"}, d, e.data);
                last_v[id]  = e.data;
                last_dc[id] = e.dc;
            end
        end else begin
            if (!last_dc[id]) check({pfx, "_hold"}, d, last_v[id]);
            if (qs > 0) begin
                e = (id == 0) ? q0[0] : q1[0];
                if (e.at <= edge_no) begin
                    compared++;
                    mismatched++;
                    $display("FAIL %s_missing_valid: got dout_valid=0 required dout_valid=1 (edge %0d)",
                             pfx, edge_no);
                    if (id == 0) void'(q0.pop_front());
                    else         void'(q1.pop_front());
                end
            end
        end
    endtask

    always @(negedge clk) begin
        bit expb;
        if (started && !rst) begin
            check_out(0, dout0, v0);
            check_out(1, dout1, v1);
            expb = (clr_edge >= 0) && (edge_no >= clr_edge) && (edge_no < clr_edge + 16);
            check("busy0", busy0, expb);
            check("busy1", busy1, expb);
        end
    end

    // One clock: drive inputs, let the edge happen, then advance the reference model.
    task automatic step(input logic e, input logic w, input logic [1:0] b,
                        input logic [3:0] a, input logic [15:0] d, input logic c);
        logic [15:0] old, merged;
        bit          mb;
        en = e; we = w; be = b; addr = a; din = d; clr = c;
        @(posedge clk);
        edge_no++;
        mb = m_busy_at(edge_no);
        if (e && !mb) begin
            old    = m_mem[a];
            merged = old;
            for (int i = 0; i < 2; i++) if (b[i]) merged[8*i +: 8] = d[8*i +: 8];
            q0.push_back('{old, !m_known[a], edge_no});
            q1.push_back('{(w ? merged : old), (!m_known[a] && !(w && b == 2'b11)), edge_no + 1});
            if (w) begin
                m_mem[a] = merged;
                if (b == 2'b11) m_known[a] = 1'b1;
            end
        end
        if (clr_edge >= 0 && edge_no == clr_edge + 16) begin
            for (int i = 0; i < 16; i++) begin
                m_mem[i]   = 16'h0000;
                m_known[i] = 1'b1;
            end
        end
        if (c && !mb) clr_edge = edge_no;
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] b);
        step(1'b1, 1'b1, b, a, d, 1'b0);
    endtask

    task automatic rd(input logic [3:0] a);
        step(1'b1, 1'b0, 2'($urandom_range(0, 3)), a, 16'($urandom), 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'b00, 4'd0, 16'd0, 1'b0);
    endtask

    task automatic pulse_clr();
        step(1'b0, 1'b0, 2'b00, 4'd0, 16'd0, 1'b1);
    endtask

    task automatic abort_reset();
        int n;
        rst = 1'b1;
        en  = 1'b0;
        clr = 1'b0;
        #1;
        check("rst_busy0", busy0, 1'b0);
        check("rst_busy1", busy1, 1'b0);
        check("rst_dout0", dout0, 16'h0000);
        check("rst_dout1", dout1, 16'h0000);
        check("rst_valid0", v0, 1'b0);
        check("rst_valid1", v1, 1'b0);
        if (clr_edge >= 0 && edge_no < clr_edge + 16) begin
            n = edge_no - clr_edge;
            for (int i = 0; i < n; i++) begin
                m_mem[i]   = 16'h0000;
                m_known[i] = 1'b1;
            end
        end
        clr_edge = -1;
        q0.delete();
        q1.delete();
        last_v[0] = 16'h0000; last_v[1] = 16'h0000;
        last_dc[0] = 1'b0;    last_dc[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            edge_no++;
        end
        #1;
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            m_mem[i]   = 16'h0000;
            m_known[i] = 1'b0;
        end
        last_v[0] = 16'h0000; last_v[1] = 16'h0000;
        last_dc[0] = 1'b0;    last_dc[1] = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("init_busy0", busy0, 1'b0);
        check("init_busy1", busy1, 1'b0);
        check("init_dout0", dout0, 16'h0000);
        check("init_dout1", dout1, 16'h0000);
        check("init_valid0", v0, 1'b0);
        check("init_valid1", v1, 1'b0);
        rst = 1'b0;
        started = 1'b1;

        // Basic write/read, byte enables, read-during-write
        wr(4'd3, 16'hA55A, 2'b11);
        rd(4'd3);
        wr(4'd5, 16'h1234, 2'b11);
        wr(4'd5, 16'hFFFF, 2'b01);
        rd(4'd5);
        wr(4'd5, 16'h1234, 2'b11);
        wr(4'd5, 16'hFFFF, 2'b00);
        rd(4'd5);
        wr(4'd7, 16'h0001, 2'b11);
        wr(4'd7, 16'h00F0, 2'b11);
        rd(4'd7);
        idle(3);

        // Full clear with reads attempted during the sweep
        for (int i = 0; i < 16; i++) wr(4'(i), 16'($urandom), 2'b11);
        pulse_clr();
        for (int i = 0; i < 16; i++) rd(4'($urandom_range(0, 15)));
        for (int i = 0; i < 16; i++) rd(4'(i));
        idle(3);

        // Second clr mid-sweep must not restart it
        for (int i = 0; i < 16; i++) wr(4'(i), 16'($urandom), 2'b11);
        pulse_clr();
        idle(5);
        pulse_clr();
        idle(12);
        for (int i = 0; i < 16; i++) rd(4'(i));
        idle(2);

        // clr together with an access: the access completes, sweep follows
        wr(4'd9, 16'h1111, 2'b11);
        rd(4'd9);
        step(1'b1, 1'b1, 2'b11, 4'd9, 16'h5A5A, 1'b1);
        idle(16);
        rd(4'd9);
        idle(2);

        // Reset after six busy cycles aborts the sweep
        for (int i = 0; i < 16; i++) wr(4'(i), 16'hBEEF, 2'b11);
        pulse_clr();
        idle(6);
        abort_reset();
        for (int i = 0; i < 16; i++) rd(4'(i));
        idle(2);

        // Randomized traffic with occasional clears
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                 16'($urandom), 1'($urandom_range(0, 39) == 0));
        end
        idle(20);

        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
